// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush sequencer for the 5-stage pipeline
// rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
   parameter int MC_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memrd,
   input  logic             ex_mc,
   input  logic             ex_redirect,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_bubble,
   output logic             mc_done,
   output logic             busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0] C_ST_RUN     = 2'd0;
   localparam logic [1:0] C_ST_MC_WAIT = 2'd1;
   localparam logic [1:0] C_ST_MC_DONE = 2'd2;
   localparam logic [3:0] C_MC_INIT    = 4'(MC_LAT - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [3:0]       r_mc_cnt;
   logic [3:0]       w_mc_cnt_nxt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_load_use;
   logic             w_redirect_ev;

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign w_load_use = ex_memrd && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

   assign w_redirect_ev = !rst && ex_redirect && (r_state != C_ST_MC_WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= C_ST_RUN;
         r_mc_cnt <= 4'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_mc_cnt <= w_mc_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_mc_cnt_nxt = r_mc_cnt;
      case (r_state)
         C_ST_RUN: begin
            if (ex_redirect) begin
               w_state_nxt = C_ST_RUN;
            end else if (ex_mc) begin
               w_mc_cnt_nxt = C_MC_INIT;
               w_state_nxt  = (MC_LAT == 1) ? C_ST_MC_DONE : C_ST_MC_WAIT;
            end
         end
         C_ST_MC_WAIT: begin
            w_mc_cnt_nxt = r_mc_cnt - 4'd1;
            if (r_mc_cnt <= 4'd1) begin
               w_state_nxt = C_ST_MC_DONE;
            end
         end
         default: begin
            w_state_nxt = C_ST_RUN;
         end
      endcase
   end

   always_comb begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b0;
      idex_en      = 1'b0;
      idex_flush   = 1'b0;
      exmem_bubble = 1'b0;
      mc_done      = 1'b0;
      busy         = 1'b0;
      if (!rst) begin
         pc_en   = 1'b1;
         ifid_en = 1'b1;
         idex_en = 1'b1;
         case (r_state)
            C_ST_MC_WAIT: begin
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               idex_en      = 1'b0;
               exmem_bubble = 1'b1;
               busy         = 1'b1;
            end
            default: begin
               mc_done = (r_state == C_ST_MC_DONE);
               busy    = (r_state == C_ST_MC_DONE);
               // ex_mc in MC_DONE is the finishing op itself, not a new one
               if (ex_redirect) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (ex_mc && (r_state == C_ST_RUN)) begin
                  pc_en        = 1'b0;
                  ifid_en      = 1'b0;
                  idex_en      = 1'b0;
                  exmem_bubble = 1'b1;
               end else if (w_load_use) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!pc_en && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_redirect_ev && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : scoreboard bench, two instances (MC_LAT=4 and MC_LAT=1)
// rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

   typedef struct packed {
      logic [7:0]  ctl;   // {pc_en,ifid_en,ifid_flush,idex_en,idex_flush,exmem_bubble,mc_done,busy}
      logic [15:0] stall;
      logic [15:0] flush;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_memrd, ex_mc, ex_redirect;

   logic       a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush;
   logic       a_exmem_bubble, a_mc_done, a_busy;
   logic [3:0] a_stall_cnt, a_flush_cnt;
   logic       b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush;
   logic       b_exmem_bubble, b_mc_done, b_busy;
   logic [15:0] b_stall_cnt, b_flush_cnt;

   int checks = 0;
   int errors = 0;

   exp_t q_a[$];
   exp_t q_b[$];

   // reference model state: cycles of stall still owed, pending completion pulse
   int mc_left[2];
   bit done_pend[2];
   int scnt[2];
   int fcnt[2];
   int lat[2]  = '{4, 1};
   int cmax[2] = '{15, 65535};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MC_LAT(4), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_memrd(ex_memrd), .ex_mc(ex_mc), .ex_redirect(ex_redirect),
      .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush),
      .idex_en(a_idex_en), .idex_flush(a_idex_flush), .exmem_bubble(a_exmem_bubble),
      .mc_done(a_mc_done), .busy(a_busy), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
   );

   pipe_hazard_ctrl #(.MC_LAT(1), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_memrd(ex_memrd), .ex_mc(ex_mc), .ex_redirect(ex_redirect),
      .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
      .idex_en(b_idex_en), .idex_flush(b_idex_flush), .exmem_bubble(b_exmem_bubble),
      .mc_done(b_mc_done), .busy(b_busy), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
   );

   task automatic model_step(input int k, output exp_t e);
      bit pc, ie, ifl, de, dfl, bub, dn, bz, lu, was_done;
      e.stall = 16'(scnt[k]);
      e.flush = 16'(fcnt[k]);
      pc = 1; ie = 1; ifl = 0; de = 1; dfl = 0; bub = 0; dn = 0; bz = 0;
      lu = ex_memrd && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      if (rst) begin
         pc = 0; ie = 0; de = 0;
         mc_left[k] = 0; done_pend[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end else begin
         if (mc_left[k] > 0) begin
            pc = 0; ie = 0; de = 0; bub = 1; bz = 1;
            mc_left[k]--;
            if (mc_left[k] == 0) done_pend[k] = 1;
         end else begin
            was_done = done_pend[k];
            dn = was_done; bz = was_done;
            done_pend[k] = 0;
            if (ex_redirect) begin
               ifl = 1; dfl = 1;
               if (fcnt[k] < cmax[k]) fcnt[k]++;
            end else if (ex_mc && !was_done) begin
               pc = 0; ie = 0; de = 0; bub = 1;
               if (lat[k] == 1) done_pend[k] = 1;
               else mc_left[k] = lat[k] - 1;
            end else if (lu) begin
               pc = 0; ie = 0; dfl = 1;
            end
         end
         if (!pc && scnt[k] < cmax[k]) scnt[k]++;
      end
      e.ctl = {pc, ie, ifl, de, dfl, bub, dn, bz};
   endtask

   task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic mc, input logic rdr);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      ex_rd = rd; ex_memrd = mr; ex_mc = mc; ex_redirect = rdr;
      model_step(0, e);
      q_a.push_back(e);
      model_step(1, e);
      q_b.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // monitor: outputs are presented every cycle, compare mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q_a.size() > 0) begin
            e = q_a.pop_front();
            cmp("a_ctl", 16'({a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush,
                              a_exmem_bubble, a_mc_done, a_busy}), 16'(e.ctl));
            cmp("a_stall_cnt", 16'(a_stall_cnt), e.stall);
            cmp("a_flush_cnt", 16'(a_flush_cnt), e.flush);
         end
         if (q_b.size() > 0) begin
            e = q_b.pop_front();
            cmp("b_ctl", 16'({b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush,
                              b_exmem_bubble, b_mc_done, b_busy}), 16'(e.ctl));
            cmp("b_stall_cnt", b_stall_cnt, e.stall);
            cmp("b_flush_cnt", b_flush_cnt, e.flush);
         end
      end
   end

   initial begin
      int waited;
      rst = 1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_rd = 0; ex_memrd = 0; ex_mc = 0; ex_redirect = 0;
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // load-use on rs2, then x0 and unused-operand non-hazards
      cyc(0, 5'd1, 5'd5, 1, 1, 5'd5, 1, 0, 0);
      idle(1);
      cyc(0, 5'd0, 5'd3, 1, 0, 5'd0, 1, 0, 0);
      cyc(0, 5'd7, 5'd3, 0, 0, 5'd7, 1, 0, 0);
      // back-to-back dependent loads
      cyc(0, 5'd4, 5'd0, 1, 0, 5'd4, 1, 0, 0);
      cyc(0, 5'd6, 5'd0, 1, 0, 5'd6, 1, 0, 0);
      idle(1);
      // multi-cycle op, ex_mc held while the op sits in EX
      cyc(0, 0, 0, 0, 0, 5'd9, 0, 1, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 5'd9, 0, 1, 0);
      idle(3);
      // single-cycle ex_mc pulse
      cyc(0, 0, 0, 0, 0, 5'd9, 0, 1, 0);
      idle(6);
      // redirect beats ex_mc and a load-use match
      cyc(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1);
      idle(2);
      // reset while in MC_WAIT
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(4);
      // alternating load-use hazards to drive the narrow stall counter to saturation
      for (int i = 0; i < 40; i++) cyc(0, 5'd3, 5'd0, 1, 0, 5'd3, i[0], 0, 0);
      // randomized traffic with small register range for frequent matches
      for (int i = 0; i < 1500; i++) begin
         cyc(($urandom_range(0, 63) == 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      end
      idle(2);
      waited = 0;
      while ((q_a.size() > 0 || q_b.size() > 0) && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      if (q_a.size() > 0 || q_b.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d/%0d entries left, required 0", q_a.size(), q_b.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
